// File: rtl/db_image_writer.sv
// rtl/db_image_writer.sv - segmented note-database image builder (size header + data per segment) into BRAM
// Optional: DB_WRITER_BASE_OUT_EN adds seg_base output (per-segment base address, Hk+1).
module db_image_writer #(
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 13,
  parameter int NUM_SEG   = 4,
  parameter int MEM_DEPTH = 8192
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      sig_write_on,
  output logic                      sig_write_done,
  output logic                      err_overflow,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  input  logic                      in_nodata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_din,
  output logic [ADDR_W-1:0]         total_words
`ifdef DB_WRITER_BASE_OUT_EN
  ,
  output logic [NUM_SEG*ADDR_W-1:0] seg_base
`endif
);

  localparam int SEG_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [SEG_W-1:0]  LAST_SEG  = SEG_W'(NUM_SEG - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_HEADER = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   hdr_addr_q, hdr_addr_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   total_q, total_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;
  logic                accept;

  assign in_ready       = (state_q == S_DATA);
  assign accept         = in_valid && in_ready;
  assign sig_write_done = (state_q == S_DONE) || (state_q == S_ERR);
  assign err_overflow   = err_q;
  assign total_words    = total_q;
  assign mem_we         = mem_we_q;
  assign mem_en         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_din        = mem_din_q;

  always_comb begin
    state_d    = state_q;
    hdr_addr_d = hdr_addr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    seg_d      = seg_q;
    err_d      = err_q;
    total_d    = total_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;

    case (state_q)
      S_IDLE: begin
        if (sig_write_on) begin
          state_d    = S_DATA;
          err_d      = 1'b0;
          total_d    = '0;
          hdr_addr_d = '0;
          wr_ptr_d   = ADDR_W'(1);
          count_d    = '0;
          seg_d      = '0;
        end
      end
      S_DATA: begin
        if (accept) begin
          if (!in_nodata) begin
            mem_we_d   = 1'b1;
            mem_addr_d = wr_ptr_q;
            mem_din_d  = in_data;
            wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
            count_d    = count_q + ADDR_W'(1);
            // The final data word of the final segment may land on the top address; anything else there overflows.
            if ((wr_ptr_q >= LAST_ADDR) && !(in_last && (seg_q == LAST_SEG))) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else if (in_last) begin
              state_d = S_HEADER;
            end
          end else if (in_last) begin
            state_d = S_HEADER;
          end
        end
      end
      S_HEADER: begin
        mem_we_d   = 1'b1;
        mem_addr_d = hdr_addr_q;
        mem_din_d  = DATA_W'(count_q);
        hdr_addr_d = wr_ptr_q;
        wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
        count_d    = '0;
        if (seg_q == LAST_SEG) begin
          state_d = S_DONE;
          total_d = wr_ptr_q;
        end else begin
          state_d = S_DATA;
          seg_d   = seg_q + SEG_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      hdr_addr_q <= '0;
      wr_ptr_q   <= ADDR_W'(1);
      count_q    <= '0;
      seg_q      <= '0;
      err_q      <= 1'b0;
      total_q    <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      hdr_addr_q <= hdr_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      seg_q      <= seg_d;
      err_q      <= err_d;
      total_q    <= total_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

`ifdef DB_WRITER_BASE_OUT_EN
  logic [ADDR_W-1:0] base_q [NUM_SEG];
  logic [ADDR_W-1:0] base_d [NUM_SEG];

  always_comb begin
    for (int k = 0; k < NUM_SEG; k++) base_d[k] = base_q[k];
    if ((state_q == S_IDLE) && sig_write_on) begin
      for (int k = 0; k < NUM_SEG; k++) base_d[k] = '0;
    end else if (state_q == S_HEADER) begin
      base_d[seg_q] = hdr_addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    for (int k = 0; k < NUM_SEG; k++) begin
      if (RESET) base_q[k] <= '0;
      else       base_q[k] <= base_d[k];
    end
  end

  for (genvar g = 0; g < NUM_SEG; g++) begin : g_base
    assign seg_base[g*ADDR_W +: ADDR_W] = base_q[g];
  end
`endif

endmodule

// File: tb/tb_db_image_writer.sv
// tb/tb_db_image_writer.sv - directed self-checking bench for db_image_writer
module tb_db_image_writer;
  localparam int DW = 24;
  localparam int AW = 13;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RESET = 1'b1;
  logic          a_start = 1'b0, b_start = 1'b0;
  logic          in_valid = 1'b0, in_last = 1'b0, in_nodata = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          a_done, a_err, a_ready, a_en, a_we;
  logic [AW-1:0] a_addr, a_total;
  logic [DW-1:0] a_din;
  logic          b_done, b_err, b_ready, b_en, b_we;
  logic [AW-1:0] b_addr, b_total;
  logic [DW-1:0] b_din;
`ifdef DB_WRITER_BASE_OUT_EN
  logic [4*AW-1:0] a_base;
  logic [2*AW-1:0] b_base;
`endif

  db_image_writer #(.DATA_W(DW), .ADDR_W(AW), .NUM_SEG(4), .MEM_DEPTH(8192)) u_a (
    .CLK(CLK), .RESET(RESET), .sig_write_on(a_start), .sig_write_done(a_done),
    .err_overflow(a_err), .in_valid(in_valid), .in_ready(a_ready), .in_data(in_data),
    .in_last(in_last), .in_nodata(in_nodata), .mem_en(a_en), .mem_we(a_we),
    .mem_addr(a_addr), .mem_din(a_din), .total_words(a_total)
`ifdef DB_WRITER_BASE_OUT_EN
    , .seg_base(a_base)
`endif
  );

  db_image_writer #(.DATA_W(DW), .ADDR_W(AW), .NUM_SEG(2), .MEM_DEPTH(8)) u_b (
    .CLK(CLK), .RESET(RESET), .sig_write_on(b_start), .sig_write_done(b_done),
    .err_overflow(b_err), .in_valid(in_valid), .in_ready(b_ready), .in_data(in_data),
    .in_last(in_last), .in_nodata(in_nodata), .mem_en(b_en), .mem_we(b_we),
    .mem_addr(b_addr), .mem_din(b_din), .total_words(b_total)
`ifdef DB_WRITER_BASE_OUT_EN
    , .seg_base(b_base)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int a_dones = 0, b_dones = 0, en_bad = 0;
  bit sel = 1'b0;
  logic [AW-1:0] a_la[$], b_la[$];
  logic [DW-1:0] a_ld[$], b_ld[$];
  int            exp_addr [10];
  logic [DW-1:0] exp_data [10];

  always @(negedge CLK) begin
    if (a_we) begin a_la.push_back(a_addr); a_ld.push_back(a_din); end
    if (b_we) begin b_la.push_back(b_addr); b_ld.push_back(b_din); end
    if (a_en !== a_we || b_en !== b_we) en_bad++;
    if (a_done) a_dones++;
    if (b_done) b_dones++;
  end

  function automatic logic [DW-1:0] dval(input int i);
    return 24'hA50000 + DW'(i * 37);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    @(negedge CLK);
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit l, input bit nd);
    int n = 0;
    @(negedge CLK);
    in_valid = 1'b1; in_data = d; in_last = l; in_nodata = nd;
    while (!(sel ? b_ready : a_ready) && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check_eq("beat_accept", 64'(n < 20), 64'd1);
    @(posedge CLK);
    #1;
    in_valid = 1'b0; in_last = 1'b0; in_nodata = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while ((sel ? b_dones : a_dones) < target && n < 40) begin
      @(posedge CLK);
      n++;
    end
    #1;
    check_eq("done_seen", 64'((sel ? b_dones : a_dones) >= target), 64'd1);
  endtask

  task automatic run_image(input bit toggle, input bit poke);
    pulse_start();
    if (toggle) @(negedge CLK);
    send(dval(0), 1'b0, 1'b0);
    if (toggle) @(negedge CLK);
    send(dval(1), 1'b1, 1'b0);
    if (toggle) @(negedge CLK);
    send('0, 1'b1, 1'b1);
    if (toggle) @(negedge CLK);
    send(dval(2), 1'b0, 1'b0);
    if (poke) pulse_start();
    if (toggle) @(negedge CLK);
    send(dval(3), 1'b0, 1'b0);
    if (toggle) @(negedge CLK);
    send(dval(4), 1'b1, 1'b0);
    if (toggle) @(negedge CLK);
    send(dval(5), 1'b1, 1'b0);
  endtask

  task automatic check_image(input string tag, input int target);
    wait_done(target);
    check_eq({tag, "_total"}, 64'(a_total), 64'd10);
    check_eq({tag, "_err"}, 64'(a_err), 64'd0);
`ifdef DB_WRITER_BASE_OUT_EN
    check_eq({tag, "_base"}, 64'(a_base), 64'({13'd9, 13'd5, 13'd4, 13'd1}));
`endif
    repeat (5) @(negedge CLK);
    check_eq({tag, "_dones"}, 64'(a_dones), 64'(target));
    check_eq({tag, "_nwr"}, 64'(a_la.size()), 64'd10);
    for (int i = 0; i < 10 && i < a_la.size(); i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), 64'(a_la[i]), 64'(exp_addr[i]));
      check_eq($sformatf("%s_data%0d", tag, i), 64'(a_ld[i]), 64'(exp_data[i]));
    end
  endtask

  task automatic clear_logs();
    a_la.delete(); a_ld.delete(); b_la.delete(); b_ld.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_a_we"}, 64'(a_we), 64'd0);
    check_eq({tag, "_a_ready"}, 64'(a_ready), 64'd0);
    check_eq({tag, "_a_misc"}, 64'({a_done, a_err, a_addr, a_din, a_total}), 64'd0);
    check_eq({tag, "_b_misc"}, 64'({b_we, b_ready, b_done, b_err, b_total}), 64'd0);
`ifdef DB_WRITER_BASE_OUT_EN
    check_eq({tag, "_a_base"}, 64'(a_base), 64'd0);
`endif
  endtask

  initial begin
    exp_addr = '{1, 2, 0, 3, 5, 6, 7, 4, 9, 8};
    exp_data[0] = dval(0); exp_data[1] = dval(1); exp_data[2] = 24'd2; exp_data[3] = 24'd0;
    exp_data[4] = dval(2); exp_data[5] = dval(3); exp_data[6] = dval(4); exp_data[7] = 24'd3;
    exp_data[8] = dval(5); exp_data[9] = 24'd1;

    repeat (3) @(negedge CLK);
    check_zero_outputs("reset");
    RESET = 1'b0;
    @(negedge CLK);
    check_zero_outputs("post_reset");

    sel = 1'b0;
    clear_logs();
    run_image(1'b0, 1'b0);
    check_image("t1", 1);

    clear_logs();
    run_image(1'b1, 1'b0);
    check_image("t2", 2);

    clear_logs();
    run_image(1'b0, 1'b1);
    check_image("t3", 3);

    sel = 1'b1;
    clear_logs();
    pulse_start();
    for (int i = 0; i < 7; i++) send(dval(10 + i), 1'b0, 1'b0);
    @(negedge CLK);
    check_eq("ovf_ready", 64'(b_ready), 64'd0);
    wait_done(1);
    check_eq("ovf_err", 64'(b_err), 64'd1);
    check_eq("ovf_total", 64'(b_total), 64'd0);
    repeat (3) @(negedge CLK);
    check_eq("ovf_nwr", 64'(b_la.size()), 64'd7);
    check_eq("ovf_dones", 64'(b_dones), 64'd1);
    for (int i = 0; i < 7 && i < b_la.size(); i++)
      check_eq($sformatf("ovf_addr%0d", i), 64'(b_la[i]), 64'(i + 1));
    if (b_la.size() == 7) check_eq("ovf_last_data", 64'(b_ld[6]), 64'(dval(16)));

    clear_logs();
    pulse_start();
    check_eq("restart_err_clr", 64'(b_err), 64'd0);
    send(dval(20), 1'b1, 1'b0);
    send('0, 1'b1, 1'b1);
    wait_done(2);
    check_eq("restart_total", 64'(b_total), 64'd3);
`ifdef DB_WRITER_BASE_OUT_EN
    check_eq("restart_base", 64'(b_base), 64'({13'd3, 13'd1}));
`endif
    repeat (3) @(negedge CLK);
    check_eq("restart_nwr", 64'(b_la.size()), 64'd3);
    if (b_la.size() == 3) begin
      check_eq("restart_w0", 64'({b_la[0], b_ld[0]}), 64'({13'd1, dval(20)}));
      check_eq("restart_w1", 64'({b_la[1], b_ld[1]}), 64'({13'd0, 24'd1}));
      check_eq("restart_w2", 64'({b_la[2], b_ld[2]}), 64'({13'd2, 24'd0}));
    end

    sel = 1'b0;
    pulse_start();
    send(dval(0), 1'b0, 1'b0);
    send(dval(1), 1'b1, 1'b0);
    send('0, 1'b1, 1'b1);
    send(dval(2), 1'b0, 1'b0);
    send(dval(3), 1'b0, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check_zero_outputs("midreset");
    @(negedge CLK);
    RESET = 1'b0;
    check_eq("midreset_dones", 64'(a_dones), 64'd3);
    clear_logs();
    run_image(1'b0, 1'b0);
    check_image("t5", 4);

    check_eq("en_eq_we", 64'(en_bad), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
